// File: rtl/sr_ff_bank_if.sv
// sr_ff_bank_if: bundles the set/reset inputs and flag/state outputs of sr_ff_bank
//   en, S, R, clr_illegal : driven by the master (event sources)
//   Q, Q_bar, illegal, illegal_cnt : driven by the slave (the flip-flop bank)
interface sr_ff_bank_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    logic             en;
    logic             clr_illegal;
    logic [N-1:0]     S;
    logic [N-1:0]     R;
    logic [N-1:0]     Q;
    logic [N-1:0]     Q_bar;
    logic [N-1:0]     illegal;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (output en, S, R, clr_illegal, input Q, Q_bar, illegal, illegal_cnt);
    modport slave  (input en, S, R, clr_illegal, output Q, Q_bar, illegal, illegal_cnt);
endinterface

// File: rtl/sr_ff_bank.sv
// sr_ff_bank: bank of N clocked SR flip-flops with compile-time S=R=1 resolution
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   bus.en            : global update enable
//   bus.S / bus.R     : per-channel set / reset
//   bus.clr_illegal   : clears sticky illegal flags and counter
//   bus.Q / bus.Q_bar : channel state and its complement
//   bus.illegal       : sticky per-channel S=R=1 flag
//   bus.illegal_cnt   : saturating count of cycles with any S=R=1
//                       (built only when SR_FF_BANK_ILLEGAL_CNT_EN is defined, else 0)
//   MODE: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle
module sr_ff_bank #(
    parameter int           N         = 4,
    parameter int           MODE      = 0,
    parameter logic [N-1:0] RESET_VAL = {N{1'b0}},
    parameter int           CNT_W     = 8
) (
    input logic         clk,
    input logic         rst,
    sr_ff_bank_if.slave bus
);
    typedef enum logic {LO = 1'b0, HI = 1'b1} state_t;

    if (MODE < 0 || MODE > 3) begin : g_bad_mode
        $error("sr_ff_bank: MODE must be 0..3");
    end
    if (N < 1 || N > 32) begin : g_bad_n
        $error("sr_ff_bank: N must be 1..32");
    end

    logic [N-1:0] ill_ev;
    logic [N-1:0] illegal;

    assign ill_ev = bus.en ? (bus.S & bus.R) : '0;

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t state, nxt;
        always_ff @(posedge clk) begin
            state <= rst ? (RESET_VAL[i] ? HI : LO) : nxt;
        end
        always_comb begin
            nxt = state;
            if (bus.en) begin
                case ({bus.S[i], bus.R[i]})
                    2'b10:   nxt = HI;
                    2'b01:   nxt = LO;
                    2'b11:   nxt = (MODE == 1) ? HI :
                                   (MODE == 2) ? LO :
                                   (MODE == 3) ? ((state == HI) ? LO : HI) : state;
                    default: nxt = state;
                endcase
            end
        end
        assign bus.Q[i] = (state == HI);
    end

    assign bus.Q_bar = ~bus.Q;

    // New events are OR-ed after the clear so a same-cycle set wins.
    always_ff @(posedge clk) begin
        illegal <= rst ? '0 : ((bus.clr_illegal ? '0 : illegal) | ill_ev);
    end
    assign bus.illegal = illegal;

`ifdef SR_FF_BANK_ILLEGAL_CNT_EN
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (bus.clr_illegal)
            cnt <= CNT_W'(|ill_ev);
        else if (|ill_ev && !(&cnt))
            cnt <= cnt + CNT_W'(1);
    end
    assign bus.illegal_cnt = cnt;
`else
    assign bus.illegal_cnt = '0;
`endif
endmodule
